apb_rambus_bridge: RTL and testbench
====================================

APB_RAMBUS_BRIDGE -- requirements
Module: apb_rambus_bridge

Interface
Parameters (name, default, meaning):
REQ-001 ADDR_W, 14, RamBus address width; PADDR is the same width.
REQ-002 DATA_W, 32, data width on both sides.
REQ-003 TIMEOUT, 255, number of cycles to wait for RamBusAck before aborting; legal range 1..65535.

Ports (name, direction, width, meaning):
REQ-004 clk  in  1  single clock, rising edge; both the APB and RamBus sides run on it.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 PSEL  in  1  APB3 slave select from the MSS fabric interface.
REQ-007 PENABLE  in  1  APB access phase.
REQ-008 PWRITE  in  1  1 = write, 0 = read.
REQ-009 PADDR  in  ADDR_W  APB byte address.
REQ-010 PWDATA  in  DATA_W  APB write data.
REQ-011 PRDATA  out  DATA_W  APB read data, registered.
REQ-012 PREADY  out  1  APB ready.
REQ-013 PSLVERR  out  1  APB error; 1 only on the cycle that reports a timeout.
REQ-014 RamBusnCs  out  1  RamBus chip select, active-low.
REQ-015 RamBusWrnRd  out  1  1 = write, 0 = read; valid whenever RamBusnCs=0.
REQ-016 RamBusLatch  out  1  one-cycle strobe that starts a RamBus transaction.
REQ-017 RamBusAddress  out  ADDR_W  registered address.
REQ-018 RamBusDataIn  out  DATA_W  registered write data, driven to the port-decoder slave.
REQ-019 RamBusDataOut  in  DATA_W  read data from the slave; sampled on the RamBusAck cycle.
REQ-020 RamBusAck  in  1  slave completion; level or pulse, at least one cycle.

Function
REQ-021 The block SHALL implement a four-state machine with states IDLE, LATCH, WAIT and DONE.
REQ-022 IDLE: on PSEL=1 and PENABLE=0 (setup phase), the block SHALL capture PADDR, PWDATA and PWRITE into registers and go to LATCH.
REQ-023 LATCH: the block SHALL drive RamBusnCs=0 and RamBusLatch=1 for exactly one cycle, load the timeout counter with TIMEOUT, and go to WAIT.
REQ-024 WAIT:
- RamBusnCs SHALL stay 0 and RamBusLatch SHALL be 0.
- The counter SHALL decrement by 1 each cycle that RamBusAck=0.
- On RamBusAck=1, the block SHALL latch RamBusDataOut into PRDATA (reads only) and go to DONE with error=0.
- If the counter reaches 0 with RamBusAck=0, the block SHALL go to DONE with error=1.
REQ-025 RamBusAck=1 on the same cycle the counter reaches 0 SHALL be treated as success (error=0).
REQ-026 DONE: the block SHALL drive PREADY=1 and PSLVERR=error for exactly one cycle, drive RamBusnCs=1, and return to IDLE.
REQ-027 PREADY SHALL be 0 in every state other than DONE.
REQ-028 Minimum latency: setup phase at cycle N, RamBusLatch at N+1, Ack sampled at N+2 earliest, PREADY at N+3 → APB transfer completes at N+3.
REQ-029 On a write, PRDATA SHALL hold its previous value.
REQ-030 On a timeout read, PRDATA SHALL be driven to all-ones (0xFFFFFFFF at the default width).
REQ-031 RamBusAck while in IDLE, LATCH or DONE SHALL be ignored.
REQ-032 A new setup phase SHALL only be accepted in IDLE; the next transfer therefore starts no earlier than one cycle after DONE.
REQ-033 If PSEL deasserts in LATCH or WAIT (protocol violation), the transaction SHALL still run to DONE without any change of behaviour.
REQ-034 The timeout counter SHALL be ceil(log2(TIMEOUT+1)) bits wide and SHALL never wrap.

Reset
REQ-035 While rst=1, and asynchronously on assertion, the following SHALL hold:
- state=IDLE;
- RamBusnCs=1, RamBusLatch=0, RamBusWrnRd=0;
- RamBusAddress=0, RamBusDataIn=0;
- PRDATA=0, PREADY=0, PSLVERR=0;
- counter=0.
REQ-036 Reset asserted in LATCH or WAIT SHALL abort the transaction with no PREADY pulse.
REQ-037 The first setup phase is accepted on the first rising clk edge after rst deasserts.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- Write: PADDR=0x0010, PWDATA=0xDEADBEEF, slave acks 2 cycles after the latch → RamBusAddress=0x0010, RamBusDataIn=0xDEADBEEF, RamBusWrnRd=1, exactly one RamBusLatch pulse, PREADY at cycle N+4, PSLVERR=0.
- Read: PADDR=0x0004, slave acks immediately with RamBusDataOut=0x12345678 → PRDATA=0x12345678 at PREADY, completing at N+3.
- Timeout with TIMEOUT=4 and no ack → PREADY=1 with PSLVERR=1 exactly 5 cycles after the latch, PRDATA=0xFFFFFFFF.
- Ack on the same cycle the counter expires → PSLVERR=0.
- rst pulsed during WAIT → RamBusnCs=1 immediately, no PREADY; a subsequent read completes normally.
- Back-to-back APB writes → two separate RamBusLatch pulses, with RamBusnCs deasserted for at least one cycle between them.

Source files
------------

// File: rtl/apb_rambus_bridge.sv
// APB3 slave to RamBus master bridge.
// One APB transfer becomes one latched RamBus access, with an ack timeout.
module apb_rambus_bridge #(
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              RamBusnCs,
   output logic              RamBusWrnRd,
   output logic              RamBusLatch,
   output logic [ADDR_W-1:0] RamBusAddress,
   output logic [DATA_W-1:0] RamBusDataIn,
   input  logic [DATA_W-1:0] RamBusDataOut,
   input  logic              RamBusAck
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LATCH,
      S_WAIT,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                wr_q, wr_d;
   logic                err_q, err_d;

   // Next-state, counter and datapath capture for the transfer sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      wr_d    = wr_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (PSEL && !PENABLE) begin
               addr_d  = PADDR;
               wdata_d = PWDATA;
               wr_d    = PWRITE;
               state_d = S_LATCH;
            end
         end
         S_LATCH: begin
            cnt_d   = CNT_INIT;
            err_d   = 1'b0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (RamBusAck) begin
               if (!wr_q) rdata_d = RamBusDataOut;
               err_d   = 1'b0;
               state_d = S_DONE;
            end else begin
               if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
               if (cnt_q <= CNT_ONE) begin
                  if (!wr_q) rdata_d = '1;
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any transfer in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
      end
   end

   // Handshake strobes decoded from the registered state.
   always_comb begin
      RamBusnCs   = 1'b1;
      RamBusLatch = 1'b0;
      PREADY      = 1'b0;
      PSLVERR     = 1'b0;
      unique case (state_q)
         S_LATCH: begin
            RamBusnCs   = 1'b0;
            RamBusLatch = 1'b1;
         end
         S_WAIT: begin
            RamBusnCs = 1'b0;
         end
         S_DONE: begin
            PREADY  = 1'b1;
            PSLVERR = err_q;
         end
         default: begin
            RamBusnCs = 1'b1;
         end
      endcase
   end

   assign RamBusWrnRd   = wr_q;
   assign RamBusAddress = addr_q;
   assign RamBusDataIn  = wdata_q;
   assign PRDATA        = rdata_q;

endmodule

// File: tb/tb_apb_rambus_bridge.sv
// Testbench for apb_rambus_bridge: transaction-level model with a
// per-cycle compare process, directed scenarios and random traffic.
module tb_apb_rambus_bridge;

   localparam int AW = 14;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          PSEL = 1'b0;
   logic          PENABLE = 1'b0;
   logic          PWRITE = 1'b0;
   logic [AW-1:0] PADDR = '0;
   logic [DW-1:0] PWDATA = '0;
   logic [DW-1:0] PRDATA;
   logic          PREADY;
   logic          PSLVERR;
   logic          RamBusnCs;
   logic          RamBusWrnRd;
   logic          RamBusLatch;
   logic [AW-1:0] RamBusAddress;
   logic [DW-1:0] RamBusDataIn;
   logic [DW-1:0] dout = '0;
   logic          ack = 1'b0;

   apb_rambus_bridge #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .PSEL(PSEL),
      .PENABLE(PENABLE),
      .PWRITE(PWRITE),
      .PADDR(PADDR),
      .PWDATA(PWDATA),
      .PRDATA(PRDATA),
      .PREADY(PREADY),
      .PSLVERR(PSLVERR),
      .RamBusnCs(RamBusnCs),
      .RamBusWrnRd(RamBusWrnRd),
      .RamBusLatch(RamBusLatch),
      .RamBusAddress(RamBusAddress),
      .RamBusDataIn(RamBusDataIn),
      .RamBusDataOut(dout),
      .RamBusAck(ack)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Current transfer as the model sees it
   bit            t_act = 0;
   int            t_s, t_done;
   bit            t_wr, t_err;
   logic [AW-1:0] t_addr;
   logic [DW-1:0] t_data, t_rd;

   // Model of the registered outputs
   logic [DW-1:0] m_prdata = '0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_din = '0;

   // Observations for the directed literal checks
   int            n_latch = 0;
   int            n_rdy = 0;
   int            lat_cyc = 0;
   int            rdy_cyc = 0;
   int            last_low = -10;
   int            gap = 0;
   bit            lat_wr = 0;
   bit            rdy_err = 0;
   logic [DW-1:0] rdy_data = '0;

   // Per-cycle compare of every output against the transfer model.
   always @(negedge clk) begin
      bit in_txn, e_ncs, e_latch, e_rdy;
      if (rst) begin
         t_act    = 0;
         m_prdata = '0;
         m_addr   = '0;
         m_din    = '0;
         chk("rst_ncs", RamBusnCs, 1);
         chk("rst_latch", RamBusLatch, 0);
         chk("rst_wrnrd", RamBusWrnRd, 0);
         chk("rst_ready", PREADY, 0);
         chk("rst_slverr", PSLVERR, 0);
         chk("rst_addr", RamBusAddress, 0);
         chk("rst_din", RamBusDataIn, 0);
         chk("rst_prdata", PRDATA, 0);
      end else begin
         in_txn = t_act && cyc > t_s && cyc <= t_done;
         if (in_txn && cyc == t_s + 1) begin
            m_addr = t_addr;
            m_din  = t_data;
         end
         if (in_txn && cyc == t_done && !t_wr)
            m_prdata = t_err ? '1 : t_rd;
         e_ncs   = !(in_txn && cyc < t_done);
         e_latch = in_txn && cyc == t_s + 1;
         e_rdy   = in_txn && cyc == t_done;
         chk("ncs", RamBusnCs, e_ncs);
         chk("latch", RamBusLatch, e_latch);
         chk("pready", PREADY, e_rdy);
         chk("pslverr", PSLVERR, e_rdy && t_err);
         if (!e_ncs) chk("wrnrd", RamBusWrnRd, t_wr);
         chk("addr", RamBusAddress, m_addr);
         chk("din", RamBusDataIn, m_din);
         chk("prdata", PRDATA, m_prdata);
         if (RamBusLatch) begin
            n_latch++;
            lat_cyc = cyc;
            lat_wr  = RamBusWrnRd;
            gap     = cyc - last_low - 1;
         end
         if (!RamBusnCs) last_low = cyc;
         if (PREADY) begin
            n_rdy++;
            rdy_cyc  = cyc;
            rdy_data = PRDATA;
            rdy_err  = PSLVERR;
         end
      end
   end

   task automatic idle(int n);
      repeat (n) begin
         PSEL    = 0;
         PENABLE = 0;
         PWRITE  = 1'($urandom);
         PADDR   = AW'($urandom);
         PWDATA  = $urandom;
         ack     = 1'($urandom_range(0, 1));
         dout    = $urandom;
         @(posedge clk);
         #1;
      end
   endtask

   // One APB transfer; slave acks d cycles into WAIT (d >= TO: never).
   // drop releases PSEL/PENABLE after setup; abort >= 0 resets in WAIT.
   task automatic do_txn(bit wr, logic [AW-1:0] a, logic [DW-1:0] wd,
                         int d, logic [DW-1:0] rd, bit drop, int abort);
      int n, dn;
      n = cyc;
      dn = (d < TO) ? n + 3 + d : n + 2 + TO;
      t_s = n;
      t_done = dn;
      t_wr = wr;
      t_addr = a;
      t_data = wd;
      t_rd = rd;
      t_err = (d >= TO);
      t_act = 1;
      for (int c = n; c <= dn; c++) begin
         PSEL    = (c == n) ? 1'b1 : !drop;
         PENABLE = (c != n) && !drop;
         PWRITE  = wr;
         PADDR   = a;
         PWDATA  = wd;
         if (c >= n + 2 && c < dn) begin
            ack  = (c == n + 2 + d);
            dout = ack ? rd : $urandom;
         end else begin
            ack  = 1'($urandom_range(0, 1));
            dout = $urandom;
         end
         if (abort >= 0 && c == n + 2 + abort) begin
            ack = 0;
            #2 rst = 1;
            #1;
            chk("abort_ncs", RamBusnCs, 1);
            chk("abort_ready", PREADY, 0);
            chk("abort_latch", RamBusLatch, 0);
            t_act = 0;
            @(posedge clk);
            #1;
            rst = 0;
            PSEL = 0;
            PENABLE = 0;
            return;
         end
         @(posedge clk);
         #1;
      end
      PSEL    = 0;
      PENABLE = 0;
      ack     = 1'($urandom_range(0, 1));
   endtask

   initial begin
      int n0, r0;
      bit w;
      int d, ab;
      repeat (3) @(posedge clk);
      #1;
      rst = 0;

      // Write taken on the first edge after reset, ack 2 cycles after latch
      n_latch = 0;
      n0 = cyc;
      do_txn(1, 14'h0010, 32'hDEADBEEF, 1, 32'h0, 0, -1);
      chk("wr_latches", n_latch, 1);
      chk("wr_latency", rdy_cyc - n0, 4);
      chk("wr_err", rdy_err, 0);
      chk("wr_wrnrd", lat_wr, 1);
      chk("wr_addr", RamBusAddress, 14'h0010);
      chk("wr_din", RamBusDataIn, 32'hDEADBEEF);
      idle(1);

      // Read with immediate ack
      n0 = cyc;
      do_txn(0, 14'h0004, 32'h0, 0, 32'h12345678, 0, -1);
      chk("rd_latency", rdy_cyc - n0, 3);
      chk("rd_data", rdy_data, 32'h12345678);
      chk("rd_addr", RamBusAddress, 14'h0004);
      idle(2);

      // Timeout read
      do_txn(0, 14'h0008, 32'h0, TO, 32'h0, 0, -1);
      chk("to_delay", rdy_cyc - lat_cyc, 5);
      chk("to_err", rdy_err, 1);
      chk("to_data", rdy_data, 32'hFFFFFFFF);
      idle(1);

      // Ack on the expiry cycle is a success
      do_txn(0, 14'h000C, 32'h0, TO - 1, 32'hA5A50F0F, 0, -1);
      chk("exp_delay", rdy_cyc - lat_cyc, 5);
      chk("exp_err", rdy_err, 0);
      chk("exp_data", rdy_data, 32'hA5A50F0F);
      idle(1);

      // Timed-out write leaves PRDATA alone
      do_txn(1, 14'h0030, 32'h11112222, TO + 1, 32'h0, 0, -1);
      chk("wto_err", rdy_err, 1);
      chk("wto_data", rdy_data, 32'hA5A50F0F);
      idle(2);

      // Reset in WAIT: no PREADY, then a normal read
      r0 = n_rdy;
      do_txn(0, 14'h0020, 32'h0, TO + 2, 32'h0, 0, 1);
      chk("abort_no_ready", n_rdy, r0);
      do_txn(0, 14'h0024, 32'h0, 1, 32'hCAFEF00D, 0, -1);
      chk("post_rst_data", rdy_data, 32'hCAFEF00D);
      chk("post_rst_err", rdy_err, 0);

      // Back-to-back writes
      n_latch = 0;
      do_txn(1, 14'h0040, 32'h01020304, 0, 32'h0, 0, -1);
      do_txn(1, 14'h0044, 32'h05060708, 2, 32'h0, 0, -1);
      chk("b2b_latches", n_latch, 2);
      chk("b2b_gap", gap >= 1, 1);
      chk("b2b_addr", RamBusAddress, 14'h0044);

      // PSEL dropped mid-transfer still completes
      do_txn(0, 14'h0050, 32'h0, 2, 32'h55AA55AA, 1, -1);
      chk("drop_data", rdy_data, 32'h55AA55AA);
      idle(1);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         idle($urandom_range(0, 2));
         w  = 1'($urandom);
         d  = $urandom_range(0, TO + 2);
         ab = -1;
         if ($urandom_range(0, 19) == 0) begin
            ab = $urandom_range(0, TO - 1);
            d  = TO + 3;
         end
         do_txn(w, AW'($urandom), $urandom, d, $urandom,
                $urandom_range(0, 7) == 0, ab);
      end
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
